// File: rtl/logic_pipe_pkg.sv
// Shared defaults and the per-bit boolean functions of the logic pipe.
package logic_pipe_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_STAGES = 3;
    localparam int DEF_CNT_W  = 16;

    function automatic logic f_main(input logic a, input logic b, input logic c);
        return ~((a & b) | c);
    endfunction

    function automatic logic f_aux(input logic a, input logic b, input logic c);
        return ((a | b) & c) ^ a;
    endfunction

endpackage

// File: rtl/pipe_slice.sv
// One enable-controlled pipeline register: valid bit plus payload.
// Payload only loads with a valid item, so an emptied slice keeps its last value.
module pipe_slice #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic         vld_i,
    input  logic [W-1:0] dat_i,
    output logic         vld_o,
    output logic [W-1:0] dat_o
);

    logic         vld_q, vld_d;
    logic [W-1:0] dat_q, dat_d;

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (en_i) begin
            vld_d = vld_i;
            if (vld_i) begin
                dat_d = dat_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign vld_o = vld_q;
    assign dat_o = dat_q;

endmodule

// File: rtl/logic_pipe_dce.sv
// Pipelined y = ~((a&b)|c) with optional aux path; latency STAGES cycles.
// Bubble-collapsing valid/ready: a stage moves when empty or when everything ahead moves.
module logic_pipe_dce
    import logic_pipe_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES,
    parameter int AUX_EN = 0,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] aux_y,
    output logic [CNT_W-1:0] xfer_cnt
);

    localparam int PW = (AUX_EN != 0) ? 2 * WIDTH : WIDTH;

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] en;
    logic [PW-1:0]     dq [STAGES];
    logic [PW-1:0]     pay0;
    logic [WIDTH-1:0]  main_fn;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        main_fn = '0;
        for (int i = 0; i < WIDTH; i++) begin
            main_fn[i] = f_main(a[i], b[i], c[i]);
        end
    end

    // With AUX_EN=0 the aux function never reaches a register, so nothing remains to prune.
    if (AUX_EN != 0) begin : g_aux
        logic [WIDTH-1:0] aux_fn;
        always_comb begin
            aux_fn = '0;
            for (int i = 0; i < WIDTH; i++) begin
                aux_fn[i] = f_aux(a[i], b[i], c[i]);
            end
        end
        assign pay0  = {aux_fn, main_fn};
        assign aux_y = dq[STAGES-1][PW-1:WIDTH];
    end else begin : g_noaux
        assign pay0  = main_fn;
        assign aux_y = '0;
    end

    // en[i] = ~v[i] | en[i+1] unrolled, so the chain has no combinational self-reference.
    always_comb begin
        en = '0;
        for (int i = 0; i < STAGES; i++) begin
            en[i] = out_ready;
            for (int j = i; j < STAGES; j++) begin
                if (!v[j]) en[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        if (g == 0) begin : g_first
            pipe_slice #(.W(PW)) u_slice (
                .clk   (clk),
                .rst_n (rst_n),
                .en_i  (en[0]),
                .vld_i (in_valid),
                .dat_i (pay0),
                .vld_o (v[0]),
                .dat_o (dq[0])
            );
        end else begin : g_next
            pipe_slice #(.W(PW)) u_slice (
                .clk   (clk),
                .rst_n (rst_n),
                .en_i  (en[g]),
                .vld_i (v[g-1]),
                .dat_i (dq[g-1]),
                .vld_o (v[g]),
                .dat_o (dq[g])
            );
        end
    end

    assign in_ready  = en[0];
    assign out_valid = v[STAGES-1];
    assign y         = dq[STAGES-1][WIDTH-1:0];

    always_comb begin
        cnt_d = cnt_q;
        if (out_valid && out_ready && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_logic_pipe_dce.sv
// Bench for logic_pipe_dce: an aux-live build and a narrow-counter aux-dead build share stimulus.
module tb_logic_pipe_dce;

    localparam int S = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] a = '0, b = '0, c = '0;

    logic        in_ready1, out_valid1, in_ready0, out_valid0;
    logic [7:0]  y1, aux1, y0, aux0;
    logic [15:0] cnt1;
    logic [2:0]  cnt0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    logic_pipe_dce #(.WIDTH(8), .STAGES(S), .AUX_EN(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .c(c), .out_valid(out_valid1), .out_ready(out_ready),
        .y(y1), .aux_y(aux1), .xfer_cnt(cnt1)
    );

    logic_pipe_dce #(.WIDTH(8), .STAGES(S), .AUX_EN(0), .CNT_W(3)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .c(c), .out_valid(out_valid0), .out_ready(out_ready),
        .y(y0), .aux_y(aux0), .xfer_cnt(cnt0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: queue of accepted items tagged with their acceptance cycle.
    typedef struct {
        int         cyc;
        logic [7:0] y;
        logic [7:0] aux;
    } item_t;

    item_t      q[$];
    int         cyc = 0;
    int         xf = 0;
    logic [7:0] last_y = '0;
    logic [7:0] last_aux = '0;

    always @(negedge clk) begin
        logic exp_rdy, exp_ov;
        item_t it;
        if (!rst_n) begin
            q.delete();
            xf = 0;
            last_y = '0;
            last_aux = '0;
            chk("rst_out_valid1", 32'(out_valid1), 0);
            chk("rst_out_valid0", 32'(out_valid0), 0);
            chk("rst_y1", 32'(y1), 0);
            chk("rst_aux1", 32'(aux1), 0);
            chk("rst_cnt1", 32'(cnt1), 0);
            chk("rst_cnt0", 32'(cnt0), 0);
        end else begin
            exp_rdy = (q.size() < S) || out_ready;
            exp_ov  = (q.size() > 0) && (cyc >= q[0].cyc + S);
            chk("in_ready1", 32'(in_ready1), 32'(exp_rdy));
            chk("in_ready0", 32'(in_ready0), 32'(exp_rdy));
            chk("out_valid1", 32'(out_valid1), 32'(exp_ov));
            chk("out_valid0", 32'(out_valid0), 32'(exp_ov));
            if (exp_ov) begin
                chk("y1", 32'(y1), 32'(q[0].y));
                chk("y0", 32'(y0), 32'(q[0].y));
                chk("aux1", 32'(aux1), 32'(q[0].aux));
            end else begin
                chk("hold_y1", 32'(y1), 32'(last_y));
                chk("hold_y0", 32'(y0), 32'(last_y));
                chk("hold_aux1", 32'(aux1), 32'(last_aux));
            end
            chk("aux0_zero", 32'(aux0), 0);
            chk("cnt1", 32'(cnt1), (xf > 65535) ? 65535 : xf);
            chk("cnt0", 32'(cnt0), (xf > 7) ? 7 : xf);
            if (exp_ov && out_ready) begin
                last_y   = q[0].y;
                last_aux = q[0].aux;
                void'(q.pop_front());
                xf++;
            end
            if (in_valid && exp_rdy) begin
                it.cyc = cyc;
                it.y   = ~((a & b) | c);
                it.aux = ((a | b) & c) ^ a;
                q.push_back(it);
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic latency_probe(input string tag);
        step();
        out_ready = 1'b1;
        a = 8'hF0; b = 8'hCC; c = 8'h0A; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        @(negedge clk) chk({tag, "_c1_valid"}, 32'(out_valid1), 0);
        step();
        @(negedge clk) chk({tag, "_c2_valid"}, 32'(out_valid1), 0);
        step();
        @(negedge clk);
        chk({tag, "_c3_valid"}, 32'(out_valid1), 1);
        chk({tag, "_c3_y1"}, 32'(y1), 32'h35);
        chk({tag, "_c3_aux1"}, 32'(aux1), 32'hF8);
        chk({tag, "_c3_y0"}, 32'(y0), 32'h35);
        chk({tag, "_c3_aux0"}, 32'(aux0), 0);
        step();
        @(negedge clk);
        chk({tag, "_cnt_after"}, 32'(cnt1), 1);
        chk({tag, "_empty_valid"}, 32'(out_valid1), 0);
        chk({tag, "_empty_hold_y"}, 32'(y1), 32'h35);
    endtask

    task automatic pulse_reset();
        step();
        in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    logic [7:0] stall_y [4] = '{8'hFE, 8'hFD, 8'hFC, 8'hFB};

    initial begin
        // Reset state
        rst_n = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready1", 32'(in_ready1), 1);
        chk("post_rst_in_ready0", 32'(in_ready0), 1);
        chk("post_rst_valid", 32'(out_valid1), 0);
        chk("post_rst_cnt", 32'(cnt1), 0);

        latency_probe("lat");

        // Stall and fill: with b=FF, c=00 the result is ~a
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = 8'(i + 1); b = 8'hFF; c = 8'h00; in_valid = 1'b1;
            @(negedge clk) chk($sformatf("fill_in_ready_%0d", i), 32'(in_ready1), 32'(i < 3));
            step();
        end
        repeat (2) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready1), 0);
            chk("stall_valid", 32'(out_valid1), 1);
            chk("stall_y", 32'(y1), 32'(stall_y[0]));
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("drain_valid_%0d", i), 32'(out_valid1), 1);
            chk($sformatf("drain_y_%0d", i), 32'(y1), 32'(stall_y[i]));
            step();
            in_valid = 1'b0;
        end
        repeat (2) step();

        // Full-pipe streaming, 100 input cycles
        pulse_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        a = 8'($urandom()); b = 8'($urandom()); c = 8'($urandom());
        for (int i = 1; i < 100; i++) begin
            step();
            a = 8'($urandom()); b = 8'($urandom()); c = 8'($urandom());
        end
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream_cnt1", 32'(cnt1), 97);
        chk("stream_cnt0_sat", 32'(cnt0), 7);
        repeat (5) step();

        // Saturation with exactly 10 transfers
        pulse_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a = 8'($urandom()); b = 8'($urandom()); c = 8'($urandom()); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        repeat (S + 2) step();
        @(negedge clk);
        chk("sat10_cnt1", 32'(cnt1), 10);
        chk("sat10_cnt0", 32'(cnt0), 7);

        // Reset with two items in flight
        step();
        for (int i = 0; i < 2; i++) begin
            a = 8'h11; b = 8'h22; c = 8'h44; in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("midrst_no_stale_%0d", i), 32'(out_valid1), 0);
            chk($sformatf("midrst_cnt_%0d", i), 32'(cnt1), 0);
            if (i < 3) step();
        end
        latency_probe("midrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
